vdic_dut_alu_responder: RTL and testbench
=========================================

// Module: vdic_dut_alu_responder
// PURPOSE
//  Responder end of the vdic_dut word protocol. Collects a packet of 9-bit words
//  (data bytes terminated by one command word), folds the bytes with the command's
//  operation and returns the 16-bit result as two bytes with a dout_valid strobe.
//  Sits behind vdic_dut_bfm; the scoreboard samples data1_o/data2_o after dout_valid falls.
// PARAMETERS
//  MAX_WORDS  9  data-byte buffer depth, i.e. the maximum data bytes per packet (>=1)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  din         in   9   din[8]=1: command word (din[7:0]=code); din[8]=0: data byte
//  din_valid   in   1   din qualifier; a word is accepted when din_valid && din_ready
//  din_ready   out  1   high in IDLE/COLLECT, low in CALC/OUT
//  data1_o     out  8   result[15:8], held until the next result
//  data2_o     out  8   result[7:0], held until the next result
//  dout_valid  out  1   single-cycle strobe, result valid
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, count=0, acc=0, data1_o=0,
//   data2_o=0, dout_valid=0, din_ready=1.
//  Codes: NOP=8'h00 AND=8'h01 OR=8'h02 XOR=8'h03 ADD=8'h10 SUB=8'h20; others are illegal.
//  FSM:
//   IDLE: an accepted data byte -> buf[0], count=1, go to COLLECT.
//    An accepted command -> len error, go to OUT.
//   COLLECT: an accepted data byte -> buf[count], count++. If count==MAX_WORDS,
//    extra bytes are dropped and the overflow flag is set.
//    An accepted command -> latch code, go to CALC.
//   CALC: one cycle per buffered byte. The first cycle loads acc={8'h0,buf[0]};
//    each later cycle computes acc = acc OP {8'h0,buf[i]}.
//    After count cycles, go to OUT.
//   OUT: registers {data1_o,data2_o}=acc and pulses dout_valid for 1 cycle.
//    Next cycle -> IDLE, count=0.
//  Latency: command accepted at edge T -> dout_valid high in cycle T+count+1.
//  Arithmetic: 16-bit, ADD/SUB wrap mod 2^16 (e.g. 0-1 = 16'hFFFF), no saturation.
//   NOP always yields 0. A single byte yields that byte, except with NOP.
//  Errors: illegal code, zero data bytes, or overflow -> result forced to 16'h0000.
//   dout_valid is still pulsed, so the initiator never hangs.
//  din_valid while din_ready=0: the word is ignored and not buffered.
//  Reset mid-packet or mid-CALC: the packet is discarded; dout_valid is not pulsed.
//  dout_valid is never asserted on two consecutive cycles.
// CONFIGURATION
//  VDIC_DUT_STATUS_EN defined: adds port status_o (out, 4).
//   Bits: [0] illegal cmd, [1] zero length, [2] overflow, [3] ADD carry / SUB borrow
//   out of bit 15 (sticky within the packet).
//   status_o is updated with data1_o/data2_o, held until the next result, and resets to 0.
//  Not defined: no status_o port. Errors are visible only as the 16'h0000 result.
//  Datapath timing is identical in both builds.
// TESTING
//  1. Bytes 8'h12,8'h34 + ADD -> {data1_o,data2_o}=16'h0046, dout_valid 1 cycle,
//     3 cycles after the command.
//  2. Bytes 8'h00,8'h01 + SUB -> 16'hFFFF; with STATUS_EN, status_o=4'b1000.
//  3. Bytes F0,3C,0F + AND/OR/XOR -> 16'h0000 / 16'h00FF / 16'h00C3.
//  4. Single byte 8'hAB + NOP -> 16'h0000; command 8'h7E alone -> 16'h0000;
//     with STATUS_EN, status_o=4'b0011.
//  5. MAX_WORDS+1 bytes of 8'hFF + ADD -> 16'h0000, status_o[2]=1.
//     din_valid words during CALC are ignored.
//  6. rst_n pulsed low during CALC -> outputs reset to 0, no dout_valid.
//     The next packet 8'h05,8'h03 + ADD -> 16'h0008.

Source files
------------

// File: rtl/vdic_dut_alu_responder_if.sv
// Word-protocol bundle between vdic_dut_bfm (master) and the ALU responder (slave).
// Optional status_o field is present when VDIC_DUT_STATUS_EN is defined.
interface vdic_dut_alu_responder_if;
  logic [8:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] data1_o;
  logic [7:0] data2_o;
  logic       dout_valid;
`ifdef VDIC_DUT_STATUS_EN
  logic [3:0] status_o;

  modport master (
    output din, din_valid,
    input  din_ready, data1_o, data2_o, dout_valid, status_o
  );
  modport slave (
    input  din, din_valid,
    output din_ready, data1_o, data2_o, dout_valid, status_o
  );
`else
  modport master (
    output din, din_valid,
    input  din_ready, data1_o, data2_o, dout_valid
  );
  modport slave (
    input  din, din_valid,
    output din_ready, data1_o, data2_o, dout_valid
  );
`endif
endinterface

// File: rtl/vdic_dut_alu_responder.sv
// Responder end of the vdic_dut word protocol: buffers data bytes, folds them with the
// command's operation and returns a 16-bit result. VDIC_DUT_STATUS_EN adds status_o.
module vdic_dut_alu_responder #(
  parameter int unsigned MAX_WORDS = 9
) (
  input logic                      clk,
  input logic                      rst_n,
  vdic_dut_alu_responder_if.slave  bus
);
  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_WORDS);

  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpAnd = 8'h01;
  localparam logic [7:0] OpOr  = 8'h02;
  localparam logic [7:0] OpXor = 8'h03;
  localparam logic [7:0] OpAdd = 8'h10;
  localparam logic [7:0] OpSub = 8'h20;

  typedef enum logic [1:0] {StIdle, StCollect, StCalc, StOut} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, idx_q;
  logic [7:0]    buf_q [MAX_WORDS];
  logic [7:0]    code_q;
  logic          ovf_q;
  logic [15:0]   acc_q;
  logic [15:0]   data_q;
  logic          dout_valid_q;

  logic          accept, is_cmd, illegal, err;
  logic [15:0]   opnd, op_res;

  assign accept  = bus.din_valid && bus.din_ready;
  assign is_cmd  = bus.din[8];
  assign opnd    = {8'h00, buf_q[idx_q]};
  assign illegal = !(code_q inside {OpNop, OpAnd, OpOr, OpXor, OpAdd, OpSub});
  assign err     = illegal || (count_q == '0) || ovf_q;

  always_comb begin
    op_res = acc_q;
    case (code_q)
      OpAnd:   op_res = acc_q & opnd;
      OpOr:    op_res = acc_q | opnd;
      OpXor:   op_res = acc_q ^ opnd;
      OpAdd:   op_res = acc_q + opnd;
      OpSub:   op_res = acc_q - opnd;
      default: op_res = acc_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = is_cmd ? StOut : StCollect;
      StCollect: if (accept && is_cmd) state_d = StCalc;
      StCalc:    if (idx_q == count_q - CW'(1)) state_d = StOut;
      StOut:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.din_ready  = (state_q == StIdle) || (state_q == StCollect);
    bus.dout_valid = dout_valid_q;
    bus.data1_o    = data_q[15:8];
    bus.data2_o    = data_q[7:0];
  end

  // Packet storage needs no reset: it is only read below count_q.
  always_ff @(posedge clk) begin
    if (accept && !is_cmd && (count_q != MaxCnt)) buf_q[count_q] <= bus.din[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      idx_q        <= '0;
      code_q       <= 8'h00;
      ovf_q        <= 1'b0;
      acc_q        <= 16'h0000;
      data_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: if (accept) begin
          if (is_cmd) code_q  <= bus.din[7:0];
          else        count_q <= CW'(1);
        end
        StCollect: if (accept) begin
          if (is_cmd)                  code_q  <= bus.din[7:0];
          else if (count_q == MaxCnt)  ovf_q   <= 1'b1;
          else                         count_q <= count_q + CW'(1);
        end
        StCalc: begin
          acc_q <= (idx_q == '0) ? {8'h00, buf_q[0]} : op_res;
          idx_q <= idx_q + CW'(1);
        end
        StOut: begin
          data_q       <= (err || code_q == OpNop) ? 16'h0000 : acc_q;
          dout_valid_q <= 1'b1;
          count_q      <= '0;
          idx_q        <= '0;
          ovf_q        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef VDIC_DUT_STATUS_EN
  logic       carry_q, step_carry;
  logic [3:0] status_q;

  // Carry out of bit 15 for ADD, borrow for SUB; the load cycle never carries.
  always_comb begin
    step_carry = 1'b0;
    if (idx_q != '0) begin
      if (code_q == OpAdd)      step_carry = ({1'b0, acc_q} + {1'b0, opnd}) > 17'h0FFFF;
      else if (code_q == OpSub) step_carry = acc_q < opnd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q  <= 1'b0;
      status_q <= 4'h0;
    end else if (state_q == StCalc) begin
      carry_q  <= carry_q | step_carry;
    end else if (state_q == StOut) begin
      status_q <= {carry_q, ovf_q, count_q == '0, illegal};
      carry_q  <= 1'b0;
    end
  end

  always_comb bus.status_o = status_q;
`endif
endmodule

// File: tb/tb_vdic_dut_alu_responder.sv
// Self-checking bench for vdic_dut_alu_responder: a list-level reference model schedules
// expected results, a per-cycle compare process checks them, and literals pin the model.
module tb_vdic_dut_alu_responder;
  localparam int MAXW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vdic_dut_alu_responder_if bus ();

  vdic_dut_alu_responder #(.MAX_WORDS(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] res;
    logic [3:0]  st;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  pkt[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_cmd_cyc = 0;
  int          last_out_cyc = 0;
  logic [15:0] last_res = 16'h0;
  logic [3:0]  last_st = 4'h0;
  logic        prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: fold the byte list with plain integer arithmetic.
  function automatic logic [19:0] model(input logic [7:0] code);
    int  n = pkt.size();
    int  used = (n > MAXW) ? MAXW : n;
    int  acc = 0;
    bit  cb = 0;
    bit  ill = !(code inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20});
    bit  err;
    logic [15:0] res;
    for (int i = 0; i < used; i++) begin
      int b = int'(pkt[i]);
      if (i == 0) acc = b;
      else case (code)
        8'h01: acc = acc & b;
        8'h02: acc = acc | b;
        8'h03: acc = acc ^ b;
        8'h10: begin acc = acc + b; if (acc > 65535) begin cb = 1; acc -= 65536; end end
        8'h20: begin if (acc < b) begin cb = 1; acc += 65536; end acc -= b; end
        default: ;
      endcase
    end
    err = ill || (n == 0) || (n > MAXW);
    res = (err || code == 8'h00) ? 16'h0 : acc[15:0];
    return {cb, n > MAXW, n == 0, ill, res};
  endfunction

  always @(negedge clk) begin
    logic exp_v;
    logic [15:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("result_late", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("dout_valid", {31'd0, bus.dout_valid}, {31'd0, exp_v});
    if (bus.dout_valid) check("no_back_to_back", {31'd0, prev_v}, 32'd0);
    if (exp_v) begin
      act = {bus.data1_o, bus.data2_o};
      check("result", {16'd0, act}, {16'd0, exp_q[0].res});
`ifdef VDIC_DUT_STATUS_EN
      check("status", {28'd0, bus.status_o}, {28'd0, exp_q[0].st});
      last_st = bus.status_o;
`endif
      last_res = act;
      last_out_cyc = cyc;
      void'(exp_q.pop_front());
    end
    prev_v = bus.dout_valid;
  end

  task automatic send_word(input logic [8:0] w);
    int n = 0;
    @(negedge clk);
    while (!bus.din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.din_ready) begin
      $display("FAIL din_ready_timeout: actual 0 required 1");
      $fatal(1);
    end
    bus.din = w;
    bus.din_valid = 1'b1;
    last_cmd_cyc = cyc + 1;
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] code);
    logic [19:0] m;
    int used;
    foreach (pkt[i]) send_word({1'b0, pkt[i]});
    send_word({1'b1, code});
    m = model(code);
    used = (pkt.size() > MAXW) ? MAXW : pkt.size();
    exp_q.push_back('{cyc: last_cmd_cyc + used + 1, res: m[15:0], st: m[19:16]});
  endtask

  task automatic wait_result();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(negedge clk);
      #1 n++;
    end
    if (exp_q.size() > 0) begin
      check("result_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    bus.din = 9'h0;
    bus.din_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2 check("rst_data1", {24'd0, bus.data1_o}, 32'd0);
    check("rst_data2", {24'd0, bus.data2_o}, 32'd0);
    check("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
    check("rst_din_ready", {31'd0, bus.din_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: ADD, latency pinned
    pkt = '{8'h12, 8'h34};
    send_packet(8'h10); wait_result();
    check("t1_add", {16'd0, last_res}, 32'h0046);
    check("t1_latency", last_out_cyc - last_cmd_cyc, 32'd3);

    // 2: SUB wraps with borrow
    pkt = '{8'h00, 8'h01};
    send_packet(8'h20); wait_result();
    check("t2_sub", {16'd0, last_res}, 32'hFFFF);
`ifdef VDIC_DUT_STATUS_EN
    check("t2_status", {28'd0, last_st}, 32'h8);
`endif

    // 3: logic ops
    pkt = '{8'hF0, 8'h3C, 8'h0F};
    send_packet(8'h01); wait_result();
    check("t3_and", {16'd0, last_res}, 32'h0000);
    send_packet(8'h02); wait_result();
    check("t3_or", {16'd0, last_res}, 32'h00FF);
    send_packet(8'h03); wait_result();
    check("t3_xor", {16'd0, last_res}, 32'h00C3);

    // 4: NOP on single byte, illegal command alone
    pkt = '{8'hAB};
    send_packet(8'h10); wait_result();
    check("t4_single", {16'd0, last_res}, 32'h00AB);
    send_packet(8'h00); wait_result();
    check("t4_nop", {16'd0, last_res}, 32'h0000);
    pkt = {};
    send_packet(8'h7E); wait_result();
    check("t4_illegal", {16'd0, last_res}, 32'h0000);
`ifdef VDIC_DUT_STATUS_EN
    check("t4_status", {28'd0, last_st}, 32'h3);
`endif

    // 5: overflow, then words offered during CALC must be ignored
    pkt = {};
    for (int i = 0; i < MAXW + 1; i++) pkt.push_back(8'hFF);
    send_packet(8'h10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_ready_low", {31'd0, bus.din_ready}, 32'd0);
      bus.din = 9'h055;
      bus.din_valid = 1'b1;
    end
    @(negedge clk) bus.din_valid = 1'b0;
    wait_result();
    check("t5_overflow", {16'd0, last_res}, 32'h0000);
`ifdef VDIC_DUT_STATUS_EN
    check("t5_status_ovf", {31'd0, last_st[2]}, 32'd1);
`endif
    pkt = '{8'h21, 8'h02};
    send_packet(8'h02); wait_result();
    check("t5_after", {16'd0, last_res}, 32'h0023);

    // 6: reset mid-CALC discards the packet
    pkt = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h10);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1 check("t6_data1", {24'd0, bus.data1_o}, 32'd0);
    check("t6_data2", {24'd0, bus.data2_o}, 32'd0);
    check("t6_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
    check("t6_din_ready", {31'd0, bus.din_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    pkt = '{8'h05, 8'h03};
    send_packet(8'h10); wait_result();
    check("t6_next", {16'd0, last_res}, 32'h0008);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
